// File: rtl/posit_add_arbiter.sv
// Round-robin front end that time-shares one posit adder between requesters A and B.
// One operation is in flight at a time; a watchdog converts a missing done into an NaR response.
module posit_add_arbiter #(
    parameter int N       = 32,
    parameter int ES      = 2,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         a_valid,
    output logic         a_ready,
    input  logic [N-1:0] a_in1,
    input  logic [N-1:0] a_in2,
    output logic         a_resp_valid,
    input  logic         a_resp_ready,
    output logic [N-1:0] a_result,
    output logic         a_err,

    input  logic         b_valid,
    output logic         b_ready,
    input  logic [N-1:0] b_in1,
    input  logic [N-1:0] b_in2,
    output logic         b_resp_valid,
    input  logic         b_resp_ready,
    output logic [N-1:0] b_result,
    output logic         b_err,

    output logic [N-1:0] add_in1,
    output logic [N-1:0] add_in2,
    output logic         add_start,
    input  logic [N-1:0] add_out,
    input  logic         add_done,

    output logic         busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    if (TIMEOUT < 2 || ES < 0) begin : g_param_check
        $error("posit_add_arbiter: TIMEOUT must be >= 2 and ES non-negative");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             owner;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;

    logic             grant_a;
    logic             grant_b;
    logic             active;
    logic             accept_a;
    logic             accept_b;
    logic             owner_resp_ready;
    logic             wait_timeout;

    // Not-a-Real: sign bit set, all other bits clear.
    function automatic logic [N-1:0] nar_word();
        logic [N-1:0] w;
        w        = '0;
        w[N-1]   = 1'b1;
        return w;
    endfunction

    // Grant is a pure function of the requests and who was served last.
    always_comb begin
        grant_a = a_valid & (~b_valid | (last_grant == REQ_B));
        grant_b = b_valid & (~a_valid | (last_grant == REQ_A));
    end

    // Outputs are forced low while reset is held so an aborted operation leaves no trace.
    assign active   = ~reset;
    assign a_ready  = active & (state == IDLE) & grant_a;
    assign b_ready  = active & (state == IDLE) & grant_b;
    assign accept_a = a_valid & a_ready;
    assign accept_b = b_valid & b_ready;

    assign add_start    = active & (state == ISSUE);
    assign busy         = active & (state != IDLE);
    assign a_resp_valid = active & (state == RESP) & (owner == REQ_A);
    assign b_resp_valid = active & (state == RESP) & (owner == REQ_B);

    assign owner_resp_ready = (owner == REQ_A) ? a_resp_ready : b_resp_ready;
    assign wait_timeout     = ~add_done & (cnt == CNT_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_a || accept_b) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (add_done || wait_timeout) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (owner_resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration history and operand capture on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= REQ_A;
            last_grant <= REQ_B;
            add_in1    <= '0;
            add_in2    <= '0;
        end else if (accept_a) begin
            owner      <= REQ_A;
            last_grant <= REQ_A;
            add_in1    <= a_in1;
            add_in2    <= a_in2;
        end else if (accept_b) begin
            owner      <= REQ_B;
            last_grant <= REQ_B;
            add_in1    <= b_in1;
            add_in2    <= b_in2;
        end
    end

    // Watchdog counts WAIT cycles; a done seen in ISSUE may belong to a previous op.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == ISSUE) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Per-requester result registers keep their last value between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_result <= '0;
            a_err    <= 1'b0;
            b_result <= '0;
            b_err    <= 1'b0;
        end else if (state == WAIT) begin
            if (add_done) begin
                if (owner == REQ_A) begin
                    a_result <= add_out;
                    a_err    <= 1'b0;
                end else begin
                    b_result <= add_out;
                    b_err    <= 1'b0;
                end
            end else if (wait_timeout) begin
                if (owner == REQ_A) begin
                    a_result <= nar_word();
                    a_err    <= 1'b1;
                end else begin
                    b_result <= nar_word();
                    b_err    <= 1'b1;
                end
            end
        end
    end

    a_ready_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(a_ready && b_ready));
    resp_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(a_resp_valid && b_resp_valid));
    start_one_cycle: assert property (@(posedge clk) disable iff (reset)
        add_start |=> !add_start);

endmodule

// File: tb/tb_posit_add_arbiter.sv
// Directed bench for posit_add_arbiter; the bench plays the adder and returns hand-computed sums.
module tb_posit_add_arbiter;

    localparam int N  = 32;
    localparam int TO = 64;

    logic          clk;
    logic          reset;
    logic          a_valid, a_ready, a_resp_valid, a_resp_ready, a_err;
    logic [N-1:0]  a_in1, a_in2, a_result;
    logic          b_valid, b_ready, b_resp_valid, b_resp_ready, b_err;
    logic [N-1:0]  b_in1, b_in2, b_result;
    logic [N-1:0]  add_in1, add_in2, add_out;
    logic          add_start, add_done, busy;

    int n_checks;
    int n_fails;

    posit_add_arbiter #(.N(N), .ES(2), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_in1        (a_in1),
        .a_in2        (a_in2),
        .a_resp_valid (a_resp_valid),
        .a_resp_ready (a_resp_ready),
        .a_result     (a_result),
        .a_err        (a_err),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_in1        (b_in1),
        .b_in2        (b_in2),
        .b_resp_valid (b_resp_valid),
        .b_resp_ready (b_resp_ready),
        .b_result     (b_result),
        .b_err        (b_err),
        .add_in1      (add_in1),
        .add_in2      (add_in2),
        .add_start    (add_start),
        .add_out      (add_out),
        .add_done     (add_done),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction for requester 'who' (0=A, 1=B). dly<0 means the adder never answers.
    task automatic serve(input logic who, input logic [31:0] i1, input logic [31:0] i2,
                         input logic [31:0] sum, input int dly, input int hold,
                         input bit stale, input bit keep);
        logic [31:0] exp_res;
        logic        exp_err;
        int          n;
        exp_res = (dly < 0) ? 32'h8000_0000 : sum;
        exp_err = (dly < 0);
        #1;
        check_eq("ready_owner", who ? b_ready : a_ready, 1);
        check_eq("ready_other", who ? a_ready : b_ready, 0);
        tick();
        if (!keep) begin
            if (who) b_valid = 1'b0;
            else     a_valid = 1'b0;
        end
        check_eq("issue_start", add_start, 1);
        check_eq("issue_in1", add_in1, i1);
        check_eq("issue_in2", add_in2, i2);
        check_eq("issue_ready", a_ready | b_ready, 0);
        if (stale) begin
            add_done = 1'b1;
            add_out  = 32'h7FFF_FFFF;
        end
        tick();
        add_done = 1'b0;
        check_eq("wait_start", add_start, 0);
        check_eq("wait_busy", busy, 1);
        if (dly < 0) begin
            n = 0;
            while (!(a_resp_valid | b_resp_valid) && n < 200) begin
                tick();
                n++;
            end
            check_eq("timeout_cycles", n, TO);
        end else begin
            repeat (dly) tick();
            add_done = 1'b1;
            add_out  = sum;
            tick();
            add_done = 1'b0;
        end
        check_eq("resp_valid_owner", who ? b_resp_valid : a_resp_valid, 1);
        check_eq("resp_valid_other", who ? a_resp_valid : b_resp_valid, 0);
        check_eq("resp_result", who ? b_result : a_result, exp_res);
        check_eq("resp_err", who ? b_err : a_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            if (who) a_valid = 1'b1;
            else     b_valid = 1'b1;
            #1;
            check_eq("hold_ready", a_ready | b_ready, 0);
            check_eq("hold_start", add_start, 0);
            check_eq("hold_result", who ? b_result : a_result, exp_res);
            check_eq("hold_err", who ? b_err : a_err, exp_err);
            check_eq("hold_valid", who ? b_resp_valid : a_resp_valid, 1);
            tick();
        end
        if (hold > 0) begin
            if (who) a_valid = 1'b0;
            else     b_valid = 1'b0;
        end
        if (who) b_resp_ready = 1'b1;
        else     a_resp_ready = 1'b1;
        tick();
        check_eq("back_idle", busy, 0);
        check_eq("resp_dropped", who ? b_resp_valid : a_resp_valid, 0);
        check_eq("result_kept", who ? b_result : a_result, exp_res);
        a_resp_ready = 1'b0;
        b_resp_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b1;
        a_valid = 1'b0; a_in1 = '0; a_in2 = '0; a_resp_ready = 1'b0;
        b_valid = 1'b0; b_in1 = '0; b_in2 = '0; b_resp_ready = 1'b0;
        add_out = '0; add_done = 1'b0;

        // Reset state, with requests present to confirm ready stays low.
        repeat (3) tick();
        a_valid = 1'b1;
        b_valid = 1'b1;
        #1;
        check_eq("rst_a_ready", a_ready, 0);
        check_eq("rst_b_ready", b_ready, 0);
        check_eq("rst_a_resp", a_resp_valid, 0);
        check_eq("rst_b_resp", b_resp_valid, 0);
        check_eq("rst_start", add_start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in1", add_in1, 0);
        check_eq("rst_a_result", a_result, 0);
        check_eq("rst_b_err", b_err, 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        reset   = 1'b0;

        // 1 + 1 = 2 from A alone.
        a_in1 = 32'h4000_0000; a_in2 = 32'h4000_0000; a_valid = 1'b1;
        serve(1'b0, 32'h4000_0000, 32'h4000_0000, 32'h4800_0000, 0, 0, 0, 0);

        // Simultaneous requests after reset: A first, then strict alternation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a_in1 = 32'h4000_0000; a_in2 = 32'hC000_0000;
        b_in1 = 32'h4800_0000; b_in2 = 32'h4000_0000;
        a_valid = 1'b1; b_valid = 1'b1;
        serve(1'b0, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000, 0, 0, 0, 1);
        serve(1'b1, 32'h4800_0000, 32'h4000_0000, 32'h4C00_0000, 2, 0, 0, 1);
        serve(1'b0, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000, 1, 0, 0, 1);
        serve(1'b1, 32'h4800_0000, 32'h4000_0000, 32'h4C00_0000, 0, 0, 0, 0);
        a_valid = 1'b0;

        // Adder never answers: NaR with error, then B is served normally.
        a_in1 = 32'h4000_0000; a_in2 = 32'h4000_0000; a_valid = 1'b1;
        serve(1'b0, 32'h4000_0000, 32'h4000_0000, 32'h0, -1, 0, 0, 0);
        b_in1 = 32'h4000_0000; b_in2 = 32'h4000_0000; b_valid = 1'b1;
        serve(1'b1, 32'h4000_0000, 32'h4000_0000, 32'h4800_0000, 1, 0, 0, 0);

        // Response back-pressure for 10 cycles.
        a_in1 = 32'h4800_0000; a_in2 = 32'h4000_0000; a_valid = 1'b1;
        serve(1'b0, 32'h4800_0000, 32'h4000_0000, 32'h4C00_0000, 0, 10, 0, 0);

        // Reset during WAIT, then a late done from the adder.
        a_in1 = 32'h4000_0000; a_in2 = 32'h4000_0000; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_resp", a_resp_valid, 0);
        tick();
        reset = 1'b0;
        check_eq("midrst_in1", add_in1, 0);
        check_eq("midrst_result", a_result, 0);
        add_done = 1'b1; add_out = 32'h1234_5678;
        tick();
        add_done = 1'b0;
        check_eq("late_done_busy", busy, 0);
        check_eq("late_done_resp", a_resp_valid, 0);
        check_eq("late_done_result", a_result, 0);
        check_eq("late_done_start", add_start, 0);
        a_valid = 1'b1;
        serve(1'b0, 32'h4000_0000, 32'h4000_0000, 32'h4800_0000, 0, 0, 0, 0);

        // Done pulses in IDLE and in ISSUE are ignored.
        add_done = 1'b1; add_out = 32'h7FFF_FFFF;
        tick();
        add_done = 1'b0;
        check_eq("idle_done_busy", busy, 0);
        check_eq("idle_done_resp", a_resp_valid | b_resp_valid, 0);
        check_eq("idle_done_result", a_result, 32'h4800_0000);
        b_in1 = 32'h4000_0000; b_in2 = 32'hC000_0000; b_valid = 1'b1;
        serve(1'b1, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000, 2, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
